axi_read_master: RTL

// - Master-side driver for the 16x8 AXI read slave: takes a burst command (base address, beat count),

---
 rtl/axi_rd_pkg.sv | 16 +
 rtl/axi_read_master_if.sv | 21 ++
 rtl/axi_rd_resp_fifo.sv | 50 +++++
 rtl/axi_read_master.sv | 138 +++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// rtl/axi_rd_pkg.sv - shared widths, FSM encoding and helpers for the AXI read master
package axi_rd_pkg;

    localparam int AXI_ADDR_W = 4;
    localparam int AXI_DATA_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // The slave has 16 locations, so burst addresses wrap 15 -> 0.
    function automatic logic [AXI_ADDR_W-1:0] addr_inc(input logic [AXI_ADDR_W-1:0] a);
        return a + AXI_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/axi_read_master_if.sv
// rtl/axi_read_master_if.sv - AR/R channel bundle between the read master and the 16x8 slave
interface axi_read_master_if;
    import axi_rd_pkg::*;

    logic [AXI_ADDR_W-1:0] read_address;
    logic                  AR_VALID;
    logic                  AR_READY;
    logic [AXI_DATA_W-1:0] data_read;
    logic                  R_VALID;
    logic                  R_READY;

    modport master (
        output read_address, AR_VALID, R_READY,
        input  AR_READY, data_read, R_VALID
    );

    modport slave (
        input  read_address, AR_VALID, R_READY,
        output AR_READY, data_read, R_VALID
    );
endinterface

// File: rtl/axi_rd_resp_fifo.sv
// rtl/axi_rd_resp_fifo.sv - synchronous response FIFO buffering R beats for the consumer
module axi_rd_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/axi_read_master.sv
// rtl/axi_read_master.sv - burst-to-single-beat AXI read master with response buffer and timeout
module axi_read_master
    import axi_rd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                     m_clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [AXI_ADDR_W-1:0]    cmd_addr,
    input  logic [AXI_ADDR_W-1:0]    cmd_len,
    axi_read_master_if.master        bus,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [AXI_DATA_W-1:0]    rsp_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]            state;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ADDR_W-1:0] len;
    logic [AXI_ADDR_W-1:0] beat_cnt;
    logic [TW-1:0]         timer;
    logic                  ar_valid;
    logic                  r_ready;

    logic                  r_hs;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  timeout_hit;
    logic                  room_after_beat;

    assign r_hs        = bus.R_VALID && r_ready;
    assign pop         = rsp_valid && rsp_ready;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));
    // Occupancy once the current beat lands; decides whether the next AR can go out at once.
    assign room_after_beat = (fifo_count < CW'(FIFO_DEPTH - 1)) || pop;

    assign bus.read_address = addr;
    assign bus.AR_VALID     = ar_valid;
    assign bus.R_READY      = r_ready;
    assign cmd_ready        = (state == ST_IDLE) && !bus.R_VALID;
    assign busy             = (state != ST_IDLE);
    assign rsp_valid        = !fifo_empty;

    axi_rd_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AXI_DATA_W)
    ) u_fifo (
        .clk       (m_clk),
        .rst       (rst),
        .push      (r_hs),
        .push_data (bus.data_read),
        .pop       (pop),
        .pop_data  (rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge m_clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            len      <= '0;
            beat_cnt <= '0;
            timer    <= '0;
            ar_valid <= 1'b0;
            r_ready  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr     <= cmd_addr;
                        len      <= cmd_len;
                        beat_cnt <= '0;
                        timer    <= '0;
                        err      <= 1'b0;
                        ar_valid <= !fifo_full;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!ar_valid) begin
                        // Parked until a slot frees; the timer is idle here by design.
                        if (!fifo_full) ar_valid <= 1'b1;
                    end else if (bus.AR_READY) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        timer    <= '0;
                        state    <= ST_DATA;
                    end else if (timeout_hit) begin
                        ar_valid <= 1'b0;
                        err      <= 1'b1;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        r_ready  <= 1'b0;
                        addr     <= addr_inc(addr);
                        beat_cnt <= beat_cnt + AXI_ADDR_W'(1);
                        timer    <= '0;
                        if (beat_cnt == len) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            ar_valid <= room_after_beat;
                            state    <= ST_ADDR;
                        end
                    end else if (timeout_hit) begin
                        r_ready <= 1'b0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
